// File: rtl/sum_bcd_converter_if.sv
// Start/Busy/Done handshake and data bus for the binary-to-BCD converter.
// master drives Start/Bin; slave (the converter) returns Busy/Done/Bcd.
interface sum_bcd_converter_if #(
   parameter int WIDTH  = 17,
   parameter int DIGITS = 6
);
   logic                  Start;
   logic [WIDTH-1:0]      Bin;
   logic                  Busy;
   logic                  Done;
   logic [4*DIGITS-1:0]   Bcd;

   modport master (
      output Start,
      output Bin,
      input  Busy,
      input  Done,
      input  Bcd
   );

   modport slave (
      input  Start,
      input  Bin,
      output Busy,
      output Done,
      output Bcd
   );
endinterface

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: one shift-add-3 step per clock,
// turns the adder's registered {Co, Sum} into packed BCD digits.
module sum_bcd_converter #(
   parameter int WIDTH  = 17,
   parameter int DIGITS = 6
) (
   input  logic Clk,
   input  logic Reset,
   sum_bcd_converter_if.slave bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [WIDTH-1:0] bin_reg, bin_n;
   logic [BW-1:0]   scratch, scratch_n;
   logic [BW-1:0]   bcd_reg, bcd_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [BW+WIDTH-1:0] cat;

   function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   always_comb begin
      state_n   = state;
      bin_n     = bin_reg;
      scratch_n = scratch;
      cnt_n     = cnt;
      bcd_n     = bcd_reg;
      cat       = {add3(scratch), bin_reg} << 1;
      unique case (state)
         IDLE, DONE: begin
            if (bus.Start) begin
               bin_n     = bus.Bin;
               scratch_n = '0;
               cnt_n     = CW'(WIDTH);
               state_n   = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         SHIFT: begin
            scratch_n = cat[BW+WIDTH-1:WIDTH];
            bin_n     = cat[WIDTH-1:0];
            cnt_n     = cnt - 1'b1;
            // last shift: publish the result on the same edge
            if (cnt == CW'(1)) begin
               bcd_n   = cat[BW+WIDTH-1:WIDTH];
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         bin_reg <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd_reg <= '0;
      end else begin
         state   <= state_n;
         bin_reg <= bin_n;
         scratch <= scratch_n;
         cnt     <= cnt_n;
         bcd_reg <= bcd_n;
      end
   end

   assign bus.Busy = (state == SHIFT);
   assign bus.Done = (state == DONE);
   assign bus.Bcd  = bcd_reg;
endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed bench for sum_bcd_converter: vector table plus
// back-to-back, ignored-Start and mid-conversion reset sequences.
module tb_sum_bcd_converter;
   logic Clk;
   logic Reset;
   int   total;
   int   bad;

   sum_bcd_converter_if #(.WIDTH(17), .DIGITS(6)) bus ();

   sum_bcd_converter #(.WIDTH(17), .DIGITS(6)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [16:0] bin;
      logic [23:0] bcd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accepts one Start, then waits (bounded) for Done.
   task automatic convert(input logic [16:0] b, output int lat,
                          output logic [23:0] res, output int busy_cnt);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Bin   = b;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!bus.Done && lat < 40) begin
         if (bus.Busy) busy_cnt++;
         @(posedge Clk);
         #1;
         lat++;
      end
      res = bus.Bcd;
   endtask

   vec_t vecs[8];
   int   lat;
   int   bcnt;
   int   dcnt;
   logic [23:0] res;

   initial begin
      total = 0;
      bad   = 0;
      bus.Start = 1'b0;
      bus.Bin   = '0;
      Reset = 1'b0;

      vecs[0] = '{17'h00000, 24'h000000};
      vecs[1] = '{17'h1FFFF, 24'h131071};
      vecs[2] = '{17'h0FFFF, 24'h065535};
      vecs[3] = '{17'h03039, 24'h012345};
      vecs[4] = '{17'h00009, 24'h000009};
      vecs[5] = '{17'h0000A, 24'h000010};
      vecs[6] = '{17'h1869F, 24'h099999};
      vecs[7] = '{17'h186A0, 24'h100000};

      repeat (2) @(posedge Clk);
      #1;
      check("reset_busy", 32'(bus.Busy), 32'd0);
      check("reset_done", 32'(bus.Done), 32'd0);
      check("reset_bcd", 32'(bus.Bcd), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         convert(vecs[i].bin, lat, res, bcnt);
         check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'd17);
         check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd17);
         check($sformatf("vec%0d_nobusy", i), 32'(bus.Busy), 32'd0);
      end

      // back-to-back: Start held during the DONE cycle
      convert(17'h0FFFF, lat, res, bcnt);
      check("b2b_first", 32'(res), 32'h065535);
      bus.Start = 1'b1;
      bus.Bin   = 17'h03039;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      check("b2b_hold", 32'(bus.Bcd), 32'h065535);
      lat = 1;
      while (!bus.Done && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      check("b2b_gap", 32'(lat), 32'd18);
      check("b2b_second", 32'(bus.Bcd), 32'h012345);

      // Start during SHIFT is ignored
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Bin   = 17'd100;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      bus.Start = 1'b1;
      bus.Bin   = 17'd999;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      dcnt = 0;
      res  = '0;
      for (int c = 0; c < 30; c++) begin
         if (bus.Done) begin
            dcnt++;
            res = bus.Bcd;
         end
         @(posedge Clk);
         #1;
      end
      check("ign_pulses", 32'(dcnt), 32'd1);
      check("ign_bcd", 32'(res), 32'h000100);

      // asynchronous reset mid-conversion
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Bin   = 17'h1FFFF;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      repeat (7) @(posedge Clk);
      #2;
      check("pre_rst_busy", 32'(bus.Busy), 32'd1);
      Reset = 1'b0;
      #1;
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_done", 32'(bus.Done), 32'd0);
      check("rst_bcd", 32'(bus.Bcd), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge Clk);
         #1;
         if (bus.Done) dcnt++;
      end
      check("rst_nodone", 32'(dcnt), 32'd0);
      convert(17'd42, lat, res, bcnt);
      check("rst_fresh", 32'(res), 32'h000042);
      check("rst_fresh_lat", 32'(lat), 32'd17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the lab 4 adder stage. It consumes the registered {Co, Sum} 17-bit result and produces six BCD digits for decimal display on the hex drivers.
- Start/Busy/Done handshake. The result register holds the last conversion until the next one completes.

Parameters:
- WIDTH, 17, width of binary input ({Co, Sum[15:0]}).
- DIGITS, 6, number of BCD digits out. Must satisfy 10^DIGITS > 2^WIDTH; the default pair does (131071 < 10^6).

Ports:
- Clk  input  1  system clock, all state on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request a conversion of Bin; sampled on posedge.
- Bin  input  WIDTH  unsigned binary value; sampled only on the edge that accepts Start.
- Busy  output  1  high while a conversion is in progress (state SHIFT).
- Done  output  1  one-cycle pulse; Bcd is valid and updated in this cycle.
- Bcd  output  4*DIGITS  packed BCD result, digit 0 in [3:0]; registered.

Behaviour:
- Reset (Reset=0, async): state=IDLE, Busy=0, Done=0, Bcd=0, internal shift/scratch registers=0, bit counter=0. Takes effect immediately, including mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; there is no combinational path from Start/Bin to outputs.
- IDLE:
  - Start=1 -> load bin_reg<=Bin, scratch<=0, cnt<=WIDTH, go SHIFT.
  - Start=0 -> stay IDLE.
- SHIFT, one iteration per cycle:
  - Each scratch digit >=5 gets +3 (4-bit add, no carry out of the digit).
  - Then {scratch, bin_reg} shift left by 1 as one concatenated register.
  - cnt decrements.
  - When cnt==1 this is the last shift: Bcd is loaded with the post-shift scratch on the same edge and state goes to DONE.
- DONE: Done=1 for exactly this cycle.
  - Start=1 -> accepted as in IDLE (back-to-back).
  - Start=0 -> IDLE.
- Busy = (state==SHIFT). Done = (state==DONE). Busy and Done are never both high.
- Latency: Start accepted on edge n -> Done=1 and Bcd valid in the cycle following edge n+WIDTH. Minimum Start-to-Start spacing is WIDTH+1 cycles.
- Start while in SHIFT is ignored; no queuing, no restart, and Bin changes are ignored.
- Bcd changes only on the final-shift edge or on reset. It holds its value through IDLE and through subsequent conversions until they finish.
- Arithmetic: unsigned only. Each digit is always 0..9 after conversion. Max input 2^WIDTH-1 converts exactly.
- Upstream Start is a level: if Start is held high, a new conversion begins on every IDLE/DONE edge.

Test Plan:
- Reset, then Bin=17'h00000, Start pulse -> Done exactly 17 cycles after the accept edge (WIDTH=17), Bcd=24'h000000, Busy high for 17 cycles.
- Bin=17'h1FFFF (Co=1, Sum=FFFF) -> Bcd=24'h131071.
- Bin=17'h0FFFF -> Bcd=24'h065535. Then Bin=17'h03039 back-to-back (Start high in the DONE cycle) -> Bcd=24'h012345 exactly 18 cycles after the first Done.
- Start at edge 0 with Bin=100; at edge 5, Bin=999 and Start=1 -> second Start ignored, Bcd=24'h000100, single Done pulse.
- Bin=17'h1FFFF conversion, then Reset low at cycle 8 -> Busy, Done and Bcd go to 0 immediately. No Done afterwards. A fresh Start with Bin=42 then yields Bcd=24'h000042.
